// File: rtl/slpf_sched_pkg.sv
// Shared types and constants for the filter-bank input scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package slpf_sched_pkg;

   localparam int ADC_N           = 6;
   localparam int ADC_W           = 12;
   localparam int CHNL_W          = 3;
   localparam int SCHED_FIFO_D    = 8;
   localparam int SCHED_ISSUE_GAP = 5;

   typedef struct packed {
      logic clk;
      logic rstn;
   } clock_t;

   typedef struct packed {
      logic [CHNL_W-1:0] chnl;
      logic [ADC_W-1:0]  data;
   } sample_t;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } sched_st_t;

endpackage

// File: rtl/slpf_sched_if.sv
// Sample ingress handshake plus the filter write port, bundled.
// Latency: n/a (wiring only).
// Backpressure: s_rdy low refuses s_val; the filter port has none.
interface slpf_sched_if;
   import slpf_sched_pkg::*;

   logic              s_val;
   logic [CHNL_W-1:0] s_chnl;
   logic [ADC_W-1:0]  s_data;
   logic              s_rdy;
   logic              f_we;
   logic [CHNL_W-1:0] f_chnl;
   logic [ADC_W-1:0]  f_di;

   modport slave  (input  s_val, s_chnl, s_data, output s_rdy, f_we, f_chnl, f_di);
   modport master (output s_val, s_chnl, s_data, input  s_rdy, f_we, f_chnl, f_di);
endinterface

// File: rtl/slpf_sched_fifo.sv
// Synchronous FIFO with extra-MSB pointers and synchronous clear.
// Latency: a push is visible at dout the cycle after it is written.
// Backpressure: push ignored while full (no pass-through), pop ignored while empty.
module slpf_sched_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign dout    = mem[rptr[AW-1:0]];

   // pointer update; clear wins over any push or pop in the same cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clr) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // storage write; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/slpf_sched.sv
// Buffers ADC samples and issues them to the filter with a minimum strobe spacing; tracks frame coverage.
// Latency: push into empty FIFO while idle with en=1 -> f_we two cycles later.
// Backpressure: s_rdy = !full; the filter port is never stalled, spacing is enforced here.
module slpf_sched
   import slpf_sched_pkg::*;
#(
   parameter int FIFO_D    = SCHED_FIFO_D,
   parameter int ISSUE_GAP = SCHED_ISSUE_GAP
) (
   input  clock_t              clock,
   input  logic                en,
   input  logic                flush,
   slpf_sched_if.slave         bus,
   output logic                frame_done,
   output logic                err_rng,
   output logic                err_dup,
   output logic                err_miss,
   output logic [7:0]          drop_cnt
);
   localparam int CW = $clog2(ISSUE_GAP) + 1;

   logic              clk;
   logic              rstn;
   sched_st_t         state;
   sched_st_t         nxt;
   logic [CW-1:0]     gap_cnt;
   sample_t           push_dat;
   sample_t           head;
   logic              full;
   logic              empty;
   logic              accept;
   logic              in_rng;
   logic              push;
   logic              pop;
   logic              last;
   logic [ADC_N-1:0]  mask;
   logic [ADC_N-1:0]  hit;
   logic              f_we_q;
   logic [CHNL_W-1:0] f_chnl_q;
   logic [ADC_W-1:0]  f_di_q;

   assign clk  = clock.clk;
   assign rstn = clock.rstn;

   // out-of-range samples are handshaken but never reach the FIFO; flush discards the push
   assign accept   = bus.s_val && !full;
   assign in_rng   = bus.s_chnl < CHNL_W'(ADC_N);
   assign push     = accept && in_rng && !flush;
   assign push_dat = {bus.s_chnl, bus.s_data};
   assign last     = (head.chnl == CHNL_W'(ADC_N - 1));
   assign hit      = ADC_N'(1) << head.chnl;

   assign bus.s_rdy  = !full;
   assign bus.f_we   = f_we_q;
   assign bus.f_chnl = f_chnl_q;
   assign bus.f_di   = f_di_q;

   slpf_sched_fifo #(
      .DEPTH (FIFO_D),
      .W     ($bits(sample_t))
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (flush),
      .push  (push),
      .din   (push_dat),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // issue FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   // pop only from IDLE; GAP holds until the spacing counter expires
   always_comb begin
      nxt = state;
      pop = 1'b0;
      case (state)
         IDLE: if (en && !empty && !flush) begin
            pop = 1'b1;
            nxt = GAP;
         end
         GAP:  if (gap_cnt == CW'(1)) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // spacing counter: loaded on issue, counts down through GAP
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                gap_cnt <= '0;
      else if (pop)                             gap_cnt <= CW'(ISSUE_GAP - 1);
      else if (state == GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
   end

   // registered filter write port; data holds between strobes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         f_we_q     <= 1'b0;
         f_chnl_q   <= '0;
         f_di_q     <= '0;
         frame_done <= 1'b0;
      end else begin
         f_we_q     <= pop;
         frame_done <= pop && last;
         if (pop) begin
            f_chnl_q <= head.chnl;
            f_di_q   <= head.data;
         end
      end
   end

   // frame coverage mask and sticky frame errors
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mask     <= '0;
         err_dup  <= 1'b0;
         err_miss <= 1'b0;
      end else if (flush) begin
         mask <= '0;
      end else if (pop) begin
         if ((mask & hit) != '0) err_dup <= 1'b1;
         if (last) begin
            if ((mask | hit) != '1) err_miss <= 1'b1;
            mask <= '0;
         end else begin
            mask <= mask | hit;
         end
      end
   end

   // range error and saturating drop counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_rng  <= 1'b0;
         drop_cnt <= '0;
      end else if (accept && !in_rng) begin
         err_rng <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end
endmodule

// File: doc/slpf_sched.md
Name: slpf_sched

Overview:
- Input-side scheduler for the single-pole low-pass filter bank.
- Accepts per-channel ADC samples from the acquisition front end over a valid/ready handshake and buffers them in a small FIFO.
- Issues samples to the filter's chnl/we/di write port with a guaranteed minimum spacing, so the filter's multi-cycle multiply-accumulate sequence is never overlapped.
- Tracks per-frame channel coverage and flags range, duplicate and missing-channel errors.

Parameters:
- ADC_N, 6 (from tdef_prm): number of filter channels; legal chnl values 0..ADC_N-1.
- ADC_W, 12 (from tdef_prm): sample width.
- FIFO_D, 8: buffer depth in entries; power of two, minimum 2.
- ISSUE_GAP, 5: minimum cycles between consecutive f_we pulses; minimum 5.

Ports:
- clock.clk  input  1  system clock; rising edge.
- clock.rstn  input  1  asynchronous, active-low reset. Delivered in clock_t as in the rest of the design; port is "clock".
- en  input  1  issue enable; acceptance into the FIFO continues while en is low.
- flush  input  1  synchronous clear of FIFO contents and frame mask.
- s_val  input  1  sample valid.
- s_chnl  input  3  sample channel.
- s_data  input  ADC_W  sample value.
- s_rdy  output  1  FIFO can accept a sample.
- f_we  output  1  one-cycle write strobe to the filter.
- f_chnl  output  3  channel to the filter; valid while f_we is high.
- f_di  output  ADC_W  sample to the filter; valid while f_we is high.
- frame_done  output  1  one-cycle pulse when channel ADC_N-1 is issued.
- err_rng  output  1  sticky: a sample with s_chnl >= ADC_N was received.
- err_dup  output  1  sticky: a channel was issued twice within one frame.
- err_miss  output  1  sticky: a frame closed with channels missing.
- drop_cnt  output  8  count of dropped out-of-range samples; saturates at 255.

Behaviour:
- Reset values: all outputs 0; FIFO empty; frame mask 0; FSM in IDLE; gap counter 0. s_rdy is 1 in the first cycle after reset release.
- Handshake and FIFO:
  - A sample is accepted on a cycle where s_val=1 and s_rdy=1.
  - s_rdy = !full, registered-free. There is no pass-through when full: a push while full is refused even if a pop occurs in the same cycle.
  - Out-of-range s_chnl: the sample is accepted (s_rdy honoured) but not written to the FIFO; err_rng is set and drop_cnt increments.
  - Simultaneous push and pop when the FIFO is neither empty nor full: both occur; occupancy is unchanged.
  - Pointers are log2(FIFO_D)+1 bits and wrap naturally. Full is indicated by MSBs differing with equal LSBs.
- Issue FSM (states IDLE, GAP):
  - IDLE: if en=1 and the FIFO is not empty, pop the head. Next cycle, drive f_we=1 with the popped f_chnl/f_di (all registered outputs), load the gap counter with ISSUE_GAP-1, and go to GAP.
  - GAP: decrement the counter each cycle; return to IDLE when it reaches 1. The next f_we is therefore no earlier than ISSUE_GAP cycles after the previous one.
  - Latency: a sample pushed into an empty FIFO while in IDLE with en=1 at cycle t reaches f_we=1 at cycle t+2.
  - en deasserted during GAP: the gap completes normally; the FSM then holds in IDLE. No partial issue ever occurs.
  - f_chnl/f_di hold their last values when f_we=0.
- Frame tracking:
  - On each issue, mask bit f_chnl is set. If that bit was already set, err_dup is set; the sample is still issued.
  - On issuing chnl ADC_N-1:
    - frame_done pulses, coincident with f_we.
    - If the mask, including the current bit, is not all ones, err_miss is set.
    - The mask then clears.
- flush:
  - Empties the FIFO and clears the mask in the next cycle.
  - Takes priority over a simultaneous push, which is discarded while s_rdy stays high that cycle, and over a simultaneous pop.
  - A gap already in progress continues.
  - flush does not clear sticky errors or drop_cnt.
- Sticky errors and drop_cnt are cleared only by reset.
- Reset asserted mid-operation: everything returns immediately (asynchronously) to reset values. f_we drops in the same cycle.

Decomposition:
- tdef_pkg gains a sample-entry typedef: a struct of a 3-bit chnl and ADC_W data.
- tdef_prm gains SCHED_FIFO_D and SCHED_ISSUE_GAP.
- One sub-module, slpf_sched_fifo: a synchronous FIFO with parameter depth, push/pop, full/empty outputs and async active-low reset.
- Issue FSM, frame mask and error logic live in slpf_sched.

Test Plan:
- Single sample: push chnl=0, data=0x123 into the idle, empty block with en=1 at cycle t -> f_we=1, f_chnl=0, f_di=0x123 at t+2; frame_done stays 0.
- Burst of 6 samples, chnl 0..5, on consecutive cycles -> f_we pulses exactly 5 cycles apart with channels in order. frame_done pulses with chnl 5; no error flags set.
- Fill with en=0: push 8 samples -> s_rdy=0 after the 8th. A 9th push is refused and retained upstream. Raising en drains all 8 entries in order.
- Errors: push chnl 7 -> err_rng=1, drop_cnt=1, nothing issued. Frame 0,1,1,3,4,5 -> err_dup=1 at the second chnl 1 and err_miss=1 at chnl 5.
- Flush with 4 entries queued while in GAP -> the gap completes, no further f_we occurs, s_rdy=1, and the mask is cleared.
- Reset asserted mid-burst, while f_we=1 -> f_we=0 asynchronously; after release all outputs are 0, s_rdy=1, and a subsequent frame issues cleanly.
